// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: op select, status flag bit positions, FSM states.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOTB = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_V = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/alu_shift_seq.sv
// Iterative one-bit-per-cycle shifter: loads A and amount on start, shifts while run.
// Latency: sh+1 cycles from start to done; done is held off while stall is high.
// Backpressure: stall freezes completion with the final value parked in the working register.
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             dir_right,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   sh,
    input  logic             run,
    input  logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             right_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work    <= '0;
            cnt     <= '0;
            right_q <= 1'b0;
        end else if (start) begin
            work    <= a;
            cnt     <= sh;
            right_q <= dir_right;
        end else if (run && (cnt != '0)) begin
            work <= right_q ? (work >> 1) : (work << 1);
            cnt  <= cnt - 1'b1;
        end
    end

    assign done = run && (cnt == '0) && !stall;
    assign res  = work;

endmodule

// File: rtl/alu_pipe.sv
// Registered 8-op ALU with valid/ready handshakes and Z/N/V status; ALU_BARREL_SHIFT_EN selects a one-cycle shifter.
// Latency: 1 cycle for all ops, except sh+1 cycles for SHL/SHR in the default iterative build.
// Backpressure: result and status hold while out_valid && !out_ready; in_ready is low then and during a shift.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       status
);

    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             accept;
    logic             out_free;

    assign out_free = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (ALUop)
            OP_ADD: begin
                alu_res = Ain + Bin;
                alu_v   = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (alu_res[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = Ain - Bin;
                alu_v   = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (alu_res[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_AND:  alu_res = Ain & Bin;
            OP_NOTB: alu_res = ~Bin;
            OP_OR:   alu_res = Ain | Bin;
            OP_XOR:  alu_res = Ain ^ Bin;
`ifdef ALU_BARREL_SHIFT_EN
            OP_SHL:  alu_res = Ain << Bin[SHW-1:0];
            OP_SHR:  alu_res = Ain >> Bin[SHW-1:0];
`endif
            default: alu_res = '0;
        endcase
    end

    function automatic logic [2:0] mk_status(input logic [WIDTH-1:0] r, input logic v);
        logic [2:0] s;
        s        = '0;
        s[FLG_Z] = (r == '0);
        s[FLG_N] = r[WIDTH-1];
        s[FLG_V] = v;
        return s;
    endfunction

`ifdef ALU_BARREL_SHIFT_EN

    assign in_ready = out_free;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= '0;
            status    <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out       <= alu_res;
            status    <= mk_status(alu_res, alu_v);
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`else

    logic [0:0]       state;
    logic             is_shift;
    logic             shift_done;
    logic [WIDTH-1:0] shift_res;

    assign is_shift = (ALUop == OP_SHL) || (ALUop == OP_SHR);
    assign in_ready = (state == ST_IDLE) && out_free;

    alu_shift_seq #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (accept && is_shift),
        .dir_right (ALUop == OP_SHR),
        .a         (Ain),
        .sh        (Bin[SHW-1:0]),
        .run       (state == ST_SHIFT),
        .stall     (!out_free),
        .done      (shift_done),
        .res       (shift_res)
    );

    // Accept already implies the output slot is free, so out_valid may drop on a shift start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            out       <= '0;
            status    <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            if (is_shift) begin
                state     <= ST_SHIFT;
                out_valid <= 1'b0;
            end else begin
                out       <= alu_res;
                status    <= mk_status(alu_res, alu_v);
                out_valid <= 1'b1;
            end
        end else if (shift_done) begin
            state     <= ST_IDLE;
            out       <= shift_res;
            status    <= mk_status(shift_res, 1'b0);
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=16); inputs change and outputs are sampled on the falling edge.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Ain;
    logic [15:0] Bin;
    logic [2:0]  ALUop;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] alu_out;
    logic [2:0]  status;

    int n_vec = 0;
    int n_err = 0;

    alu_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (alu_out),
        .status    (status)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Ain = 16'h0; Bin = 16'h0; ALUop = 3'b000;
        #1;
        n_vec++;
        if (alu_out !== 16'h0 || status !== 3'b000 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_vals out=%h status=%b vld=%b required 0000/000/0", alu_out, status, out_valid);
        end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rdy in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [2:0]  ops  [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
        logic [15:0] eres [4] = '{16'h000B, 16'h0009, 16'h0000, 16'hFFFE};
        logic [2:0]  est  [4] = '{3'b000, 3'b000, 3'b001, 3'b010};
        out_ready = 1'b1;
        Ain = 16'h000A; Bin = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; ALUop = ops[i];
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || alu_out !== eres[i] || status !== est[i] || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL basic_op%0d vld=%b out=%h status=%b rdy=%b required 1/%h/%b/1",
                         i, out_valid, alu_out, status, in_ready, eres[i], est[i]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_overflow;
        logic [15:0] av [2] = '{16'h7FFF, 16'h8000};
        logic [2:0]  ov [2] = '{3'b000, 3'b001};
        logic [15:0] er [2] = '{16'h8000, 16'h7FFF};
        logic [2:0]  es [2] = '{3'b110, 3'b100};
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; ALUop = ov[i]; Ain = av[i]; Bin = 16'h0001;
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || alu_out !== er[i] || status !== es[i]) begin
                n_err++;
                $display("FAIL ovf_%0d vld=%b out=%h status=%b required 1/%h/%b",
                         i, out_valid, alu_out, status, er[i], es[i]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_shift(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] eres, input int elat);
        int lat;
        in_valid = 1'b1; ALUop = op; Ain = a; Bin = b; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; Ain = 16'hFFFF; Bin = 16'hFFFF; ALUop = 3'b000;
        lat = 0;
        while (in_ready !== 1'b1 && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        n_vec++;
        if (lat !== elat) begin
            n_err++;
            $display("FAIL shift_lat op=%b busy_cycles=%0d required %0d", op, lat, elat);
        end
        n_vec++;
        if (out_valid !== 1'b1 || alu_out !== eres || status !== 3'b000) begin
            n_err++;
            $display("FAIL shift_res op=%b vld=%b out=%h status=%b required 1/%h/000",
                     op, out_valid, alu_out, status, eres);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        in_valid = 1'b1; ALUop = 3'b101; Ain = 16'h00FF; Bin = 16'h0F0F; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        ALUop = 3'b000; Ain = 16'h0001; Bin = 16'h0002;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || alu_out !== 16'h0FF0 || status !== 3'b000 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold_%0d vld=%b out=%h status=%b rdy=%b required 1/0ff0/000/0",
                         i, out_valid, alu_out, status, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release_rdy in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || alu_out !== 16'h0003 || status !== 3'b000) begin
            n_err++;
            $display("FAIL release_next vld=%b out=%h status=%b required 1/0003/000", out_valid, alu_out, status);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift;
        in_valid = 1'b1; ALUop = 3'b110; Ain = 16'h0001; Bin = 16'h000A; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (alu_out !== 16'h0 || status !== 3'b000 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midshift_rst out=%h status=%b vld=%b required 0000/000/0", alu_out, status, out_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_rst rdy=%b vld=%b required 1/0", in_ready, out_valid);
        end
        repeat (12) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || alu_out !== 16'h0) begin
            n_err++;
            $display("FAIL no_result vld=%b out=%h required 0/0000", out_valid, alu_out);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
`ifdef ALU_BARREL_SHIFT_EN
        test_shift(3'b110, 16'h0001, 16'h0005, 16'h0020, 0);
        test_shift(3'b111, 16'h8000, 16'h000F, 16'h0001, 0);
        test_shift(3'b110, 16'h1234, 16'h0000, 16'h1234, 0);
`else
        test_shift(3'b110, 16'h0001, 16'h0005, 16'h0020, 6);
        test_shift(3'b111, 16'h8000, 16'h000F, 16'h0001, 16);
        test_shift(3'b110, 16'h1234, 16'h0000, 16'h1234, 1);
`endif
        test_backpressure;
        test_reset_mid_shift;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
